// File: rtl/cpu_mon_pkg.sv
// Shared defaults and width helpers for the a0 result monitor.
//   DATA_WIDTH_DEF : default a0 / FIFO entry width
//   DEPTH_DEF      : default FIFO depth (power of two, >= 2)
//   CNT_WIDTH_DEF  : default drop counter width
//   ptr_w()        : FIFO index width for a given depth
//   level_w()      : occupancy width (0..depth inclusive)
package cpu_mon_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 4;
  localparam int unsigned CNT_WIDTH_DEF  = 8;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full FIFO can report DEPTH.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output (no fall-through).
//   clk   : clock
//   rst   : asynchronous active-low reset
//   push  : write request; accepted when not full, or when full with a pop
//   pop   : read request; ignored while empty
//   din   : write data
//   dout  : oldest entry, registered; valid whenever !empty
//   empty : no entries stored
//   full  : DEPTH entries stored
//   level : occupancy 0..DEPTH
module sync_fifo
  import cpu_mon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      empty,
  output logic                      full,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int unsigned PtrW = ptr_w(DEPTH);

  // Pointers carry one wrap bit above the index bits.
  logic [PtrW:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    push_en, pop_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = dout_q;

  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, push_en};
    rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, pop_en};
    dout_d   = dout_q;
    if (wr_ptr_d != rd_ptr_d) begin
      // The slot being written this edge becomes the head: bypass memory.
      if (push_en && (rd_ptr_d[PtrW-1:0] == wr_ptr_q[PtrW-1:0])) begin
        dout_d = din;
      end else begin
        dout_d = mem_q[rd_ptr_d[PtrW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  // Storage needs no reset; entries are only read once the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/a0_result_monitor.sv
// Watches the CPU a0 value and queues every change for a host to drain.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   a0_in     : a0 value from the register file
//   en        : capture enable; freezes change detection and last-seen value
//   clr       : synchronous clear of overflow and drop_cnt (FIFO untouched)
//   out_ready : consumer accepts out_data
//   out_valid : FIFO non-empty
//   out_data  : oldest queued change
//   level     : FIFO occupancy 0..DEPTH
//   overflow  : sticky, a change was dropped on a full FIFO
//   drop_cnt  : saturating count of dropped changes
module a0_result_monitor
  import cpu_mon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     a0_in,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overflow,
  output logic [CNT_WIDTH-1:0]      drop_cnt
);

  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  seen_q, seen_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  change, pop, drop;
  logic                  fifo_empty, fifo_full;

  // The first enabled sample after reset always counts as a change.
  assign change    = en && (!seen_q || (a0_in != last_q));
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = change && fifo_full && !pop;

  always_comb begin
    last_d     = last_q;
    seen_d     = seen_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // Last-seen tracks a0 even when the push is dropped, so a held value
    // is not retried on later cycles.
    if (en) begin
      last_d = a0_in;
      seen_d = 1'b1;
    end
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= '0;
      seen_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      last_q     <= last_d;
      seen_q     <= seen_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (change),
    .pop   (pop),
    .din   (a0_in),
    .dout  (out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

endmodule

// File: tb/tb_a0_result_monitor.sv
// Bench for a0_result_monitor: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_a0_result_monitor;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a0_in;
  logic          en, clr, out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    level;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_last;
  bit            m_seen;
  bit            m_ovf;
  int            m_drops;
  // Values handed to the consumer (sampled just before each edge).
  logic [DW-1:0] got[$];

  a0_result_monitor #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a0_in     (a0_in),
    .en        (en),
    .clr       (clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_seen  = 1'b0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // Advance one clock: evaluate the model on the current inputs, record any
  // handshake, then land 1 time unit after the rising edge.
  task automatic cycle();
    bit change, popv, full, acc, drop;
    change = en && (!m_seen || (a0_in != m_last));
    popv   = (m_q.size() > 0) && out_ready;
    full   = (m_q.size() == DEPTH);
    acc    = change && (!full || popv);
    drop   = change && full && !popv;
    if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
    @(posedge clk);
    #1;
    if (popv) void'(m_q.pop_front());
    if (acc) m_q.push_back(a0_in);
    if (clr) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < (1 << CW) - 1) m_drops++;
    end
    if (en) begin
      m_last = a0_in;
      m_seen = 1'b1;
    end
  endtask

  task automatic drain();
    en        = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; clr = 1'b0; out_ready = 1'b0; a0_in = '0;
    model_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== '0 ||
        overflow !== 1'b0 || drop_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b level=%0d data=%0h ovf=%b drops=%0d required 0,0,0,0,0",
               out_valid, level, out_data, overflow, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_sample();
    got.delete();
    en = 1'b1; out_ready = 1'b1; a0_in = '0;
    cycle();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_sample_visible: out_valid=%b required 1", out_valid);
    end
    cycle();
    cycle();
    checks++;
    if (got.size() != 1 || got[0] !== '0) begin
      errors++;
      $display("FAIL first_sample_once: delivered %0d entries (first %0h) required 1 entry 0",
               got.size(), got.size() > 0 ? got[0] : 'x);
    end
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL first_sample_level: level=%0d required 0", level);
    end
  endtask

  task automatic test_sequence();
    int seq[5] = '{5, 5, 7, 7, 9};
    got.delete();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a0_in = seq[i];
      cycle();
      checks++;
      if (level > 3'd1) begin
        errors++;
        $display("FAIL seq_level step %0d: level=%0d required <=1", i, level);
      end
      if (i == 0 || seq[i] != seq[i-1]) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== DW'(seq[i])) begin
          errors++;
          $display("FAIL seq_latency step %0d: valid=%b data=%0d required 1,%0d",
                   i, out_valid, out_data, seq[i]);
        end
      end
    end
    cycle();
    checks++;
    if (got.size() != 3 || got[0] !== 32'd5 || got[1] !== 32'd7 || got[2] !== 32'd9) begin
      errors++;
      $display("FAIL seq_outputs: got %p required 5,7,9", got);
    end
  endtask

  task automatic test_overflow();
    en = 1'b1; out_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      a0_in = v;
      cycle();
    end
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL overflow_state: level=%0d ovf=%b drops=%0d required 4,1,2",
               level, overflow, drop_cnt);
    end
    got.delete();
    drain();
    checks++;
    if (got.size() != 4 || got[0] !== 32'd1 || got[1] !== 32'd2 ||
        got[2] !== 32'd3 || got[3] !== 32'd4) begin
      errors++;
      $display("FAIL overflow_drain: got %p required 1,2,3,4", got);
    end
  endtask

  task automatic test_full_push_pop();
    en = 1'b1; out_ready = 1'b0;
    for (int v = 11; v <= 14; v++) begin
      a0_in = v;
      cycle();
    end
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL full_fill: level=%0d required 4", level);
    end
    got.delete();
    out_ready = 1'b1; a0_in = 8;
    cycle();
    checks++;
    if (level !== 3'd4 || drop_cnt !== 8'd2 || got.size() != 1 || got[0] !== 32'd11) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d drops=%0d popped=%0d required 4,2,11",
               level, drop_cnt, got.size() > 0 ? got[0] : 'x);
    end
  endtask

  task automatic test_clr();
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL clr_pre: ovf=%b drops=%0d required 1,2", overflow, drop_cnt);
    end
    en = 1'b1; out_ready = 1'b0; a0_in = 20; clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0 || level !== 3'd4) begin
      errors++;
      $display("FAIL clr_wins: ovf=%b drops=%0d level=%0d required 0,0,4",
               overflow, drop_cnt, level);
    end
    got.delete();
    drain();
    checks++;
    if (got.size() != 4 || got[0] !== 32'd12 || got[1] !== 32'd13 ||
        got[2] !== 32'd14 || got[3] !== 32'd8) begin
      errors++;
      $display("FAIL clr_drain: got %p required 12,13,14,8", got);
    end
  endtask

  task automatic test_mid_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int v = 30; v <= 32; v++) begin
      a0_in = v;
      cycle();
    end
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL midrst_fill: level=%0d required 3", level);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b level=%0d required 0,0", out_valid, level);
    end
    @(negedge clk);
    rst = 1'b1; a0_in = '0; en = 1'b1; out_ready = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || level !== 3'd1 || out_data !== '0) begin
      errors++;
      $display("FAIL midrst_first: valid=%b level=%0d data=%0h required 1,1,0",
               out_valid, level, out_data);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a0_in     = $urandom_range(3, 0);
      en        = ($urandom_range(9, 0) < 8);
      out_ready = $urandom_range(1, 0);
      clr       = ($urandom_range(19, 0) == 0);
      cycle();
      checks++;
      if (out_valid !== (m_q.size() > 0) || level !== 3'(m_q.size()) ||
          overflow !== m_ovf || drop_cnt !== CW'(m_drops) ||
          (m_q.size() > 0 && out_data !== m_q[0])) begin
        errors++;
        $display("FAIL random cycle %0d: valid=%b level=%0d data=%0h ovf=%b drops=%0d required %b,%0d,%0h,%b,%0d",
                 i, out_valid, level, out_data, overflow, drop_cnt, m_q.size() > 0,
                 m_q.size(), m_q.size() > 0 ? m_q[0] : 'x, m_ovf, m_drops);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_sequence();
    test_overflow();
    test_full_push_pop();
    test_clr();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
